fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Shares one single-precision floating-point multiplier (a/b/z strobe-acknowledge handshake) among `N_REQ` requesters, such as vector/cross-product engines, so that several compute blocks can time-multiplex a single multiplier instead of each instantiating their own. The block accepts one request at a time, arbitrates round-robin by default, and drives the multiplier's operand handshakes. It collects the product and returns it to the winning requester over a valid/ack response channel.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(N_REQ)`: width of the internal owner index.

Ports:
- `iClk` in 1: single clock; all logic is rising-edge.
- `iRstn` in 1: reset, asynchronous and active-low.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_a` in 32*N_REQ: operand A; requester i uses slice [32i+31:32i].
- `req_b` in 32*N_REQ: operand B; same slicing as `req_a`.
- `req_ready` out N_REQ: request accepted; at most one bit high.
- `rsp_valid` out N_REQ: product available for the owner; at most one bit high.
- `rsp_data` out 32: product; shared by all requesters.
- `rsp_ack` in N_REQ: requester consumed the response.
- `mul_data_a` out 32, `mul_data_b` out 32: multiplier operands.
- `mul_a_stb` out 1, `mul_b_stb` out 1: operand strobes.
- `mul_a_ack` in 1, `mul_b_ack` in 1: operand acknowledges.
- `mul_result` in 32: multiplier product.
- `mul_z_stb` in 1: product valid.
- `mul_z_ack` out 1: product taken.

## Operation
State machine: IDLE, ISSUE, WAIT_Z, RESP.

- **IDLE**
  - The winner is picked combinationally from `req_valid`, searching from `rr_ptr` upward with wrap-around.
  - `req_ready[winner]` is high combinationally.
  - On that edge: latch the winner's `req_a`/`req_b` into `op_a`/`op_b`, record `owner`, and go to ISSUE.
  - No `req_valid` set: stay in IDLE.
- **ISSUE**
  - `mul_a_stb` and `mul_b_stb` are registered and set high on entry; `mul_data_a`/`mul_data_b` = `op_a`/`op_b`.
  - Each strobe clears independently on the edge where `stb && ack`.
  - When both operand handshakes are complete (either order, or the same cycle), go to WAIT_Z.
- **WAIT_Z**
  - `mul_z_ack = mul_z_stb`, driven combinationally in this state only.
  - On `mul_z_stb`: latch `mul_result` into the `rsp_data` register and go to RESP.
- **RESP**
  - `rsp_valid[owner]` = 1.
  - On `rsp_ack[owner]`: go to IDLE and set `rr_ptr = owner+1`, wrapping modulo N_REQ.
  - `rsp_ack` on any other bit, or outside RESP, is ignored.

Requester obligations:
- Hold `req_a`/`req_b` stable while `req_valid` is high and `req_ready` is low.
- Deasserting `req_valid` before a grant is legal; it withdraws the request and has no side effect.
- `req_valid` held high after a grant is treated as a new request on the next IDLE visit.

## Timing
Reset values:
- All outputs are 0.
- `rsp_data` = 0, `rr_ptr` = 0, state = IDLE.

Latency and throughput:
- Grant in cycle 0.
- Strobes high in cycle 1.
- Best case with immediate acks and `mul_z_stb` one cycle later:
  - WAIT_Z in cycle 2;
  - `rsp_valid` in cycle 3;
  - next grant in cycle 4 when `rsp_ack` arrives in cycle 3.
- Throughput is at most one product per 4 cycles.

Response channel:
- `rsp_data` is stable from `rsp_valid` rise until the next `mul_z_stb` capture.
- `rsp_data` holds the last product while idle.

Reset mid-operation:
- Returns to IDLE immediately and clears strobes, `rsp_valid` and `rr_ptr`.
- The multiplier must share `iRstn`; no in-flight recovery is performed.

Simultaneous events:
- All requesters valid with `rr_ptr` = k: requester k wins.
- `mul_z_stb` already high when WAIT_Z is entered: captured on the first WAIT_Z cycle.

## Configuration
- `FP_MUL_ARB_FIXED_PRIO_EN` defined:
  - fixed priority; the lowest set index of `req_valid` wins;
  - `rr_ptr` is removed.
- Not defined: round-robin as described in Operation.

## Test plan
1. **Single request, immediate acks.**
   - Stimulus: `req_valid`=0001, A=0x40000000 (2.0), B=0x40400000 (3.0); multiplier acks immediately, `mul_z_stb` in cycle 2.
   - Required: `req_ready`=0001 in cycle 0, `rsp_valid`=0001 in cycle 3, `rsp_data`=0x40C00000 (6.0).
2. **Round-robin under full contention.**
   - Stimulus: `req_valid`=1111 held, responses acked immediately.
   - Required: grant order 0,1,2,3,0.
   - With `FP_MUL_ARB_FIXED_PRIO_EN` defined: requester 0 is granted every time.
3. **Staggered operand acks.**
   - Stimulus: `mul_b_ack` 3 cycles after `mul_a_ack`.
   - Required: `mul_a_stb` drops one cycle after its ack; `mul_b_stb` stays high until its own ack; WAIT_Z is entered only after both.
4. **Held response and stray acks.**
   - Stimulus: owner=2 withholds `rsp_ack` for 5 cycles; requester 1 pulses `rsp_ack`.
   - Required: `rsp_valid`=0100 and `rsp_data` stable for all 5 cycles; no new grant; the stray ack has no effect.
5. **Reset mid-operation.**
   - Stimulus: `iRstn` asserted low during WAIT_Z.
   - Required: all outputs 0 asynchronously; after release, `req_valid`=1000 is granted to requester 3 with `rr_ptr` restarting at 0.
6. **Withdrawn request.**
   - Stimulus: requester 1 raises then drops `req_valid` while requester 0 owns the multiplier.
   - Required: next IDLE with no valid requests stays in IDLE; no `req_ready` pulse.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter_if
//
// Bundles every signal between the multiplier arbiter and its environment:
// the N_REQ requester request/response channels and the shared single-precision
// multiplier's a/b/z strobe-acknowledge handshakes.
//
// Modports:
//   master - the arbiter's view: it drives req_ready, the response channel and
//            the multiplier operand side, and receives requests, response acks
//            and the multiplier's acks/product.
//   slave  - the environment's view (requesters plus the multiplier itself).
//
// Signals:
//   req_valid[N_REQ]      request pending, one bit per requester
//   req_a/req_b[32*N_REQ] operands; requester i uses slice [32i+31:32i]
//   req_ready[N_REQ]      request accepted (one-hot or zero)
//   rsp_valid[N_REQ]      product available for the owner (one-hot or zero)
//   rsp_data[32]          product, shared by all requesters
//   rsp_ack[N_REQ]        requester consumed the response
//   mul_data_a/b[32]      multiplier operands
//   mul_a_stb/mul_b_stb   operand strobes
//   mul_a_ack/mul_b_ack   operand acknowledges
//   mul_result[32]        multiplier product
//   mul_z_stb             product valid
//   mul_z_ack             product taken
// -----------------------------------------------------------------------------
interface fp_mul_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_data;
  logic [N_REQ-1:0]    rsp_ack;

  logic [31:0]         mul_data_a;
  logic [31:0]         mul_data_b;
  logic                mul_a_stb;
  logic                mul_b_stb;
  logic                mul_a_ack;
  logic                mul_b_ack;
  logic [31:0]         mul_result;
  logic                mul_z_stb;
  logic                mul_z_ack;

  modport master (
    input  req_valid, req_a, req_b, rsp_ack,
    input  mul_a_ack, mul_b_ack, mul_result, mul_z_stb,
    output req_ready, rsp_valid, rsp_data,
    output mul_data_a, mul_data_b, mul_a_stb, mul_b_stb, mul_z_ack
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ack,
    output mul_a_ack, mul_b_ack, mul_result, mul_z_stb,
    input  req_ready, rsp_valid, rsp_data,
    input  mul_data_a, mul_data_b, mul_a_stb, mul_b_stb, mul_z_ack
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter
//
// Time-multiplexes one single-precision floating-point multiplier among N_REQ
// requesters. One request is accepted at a time; the winner's operands are
// latched, handed to the multiplier over two independent strobe/ack
// handshakes, the product is captured and returned to the winner over a
// valid/ack response channel. Throughput is at most one product per 4 cycles.
//
// Arbitration: round-robin starting at rr_ptr, which moves to owner+1 after
// each completed response. Defining FP_MUL_ARB_FIXED_PRIO_EN selects fixed
// priority instead (lowest set req_valid index wins) and removes rr_ptr.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   IDW    owner index width
//
// Ports:
//   iClk   clock, rising edge
//   iRstn  asynchronous active-low reset; all outputs are 0 while asserted.
//          The multiplier must share this reset: nothing in flight survives.
//   bus    fp_mul_arbiter_if.master - request, response and multiplier signals
// -----------------------------------------------------------------------------
module fp_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic             iClk,
  input  logic             iRstn,
  fp_mul_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_Z = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef logic [IDW-1:0] owner_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] rsp_data_q;
  owner_t      owner;
  logic        a_stb;
  logic        b_stb;

  owner_t      winner;
  logic        any_valid;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        a_done;
  logic        b_done;
  logic        grant;
  logic        z_take;

  assign any_valid = |bus.req_valid;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  // Walk downward so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) winner = owner_t'(i);
    end
  end
`else
  typedef logic [IDW:0] idx_t;

  owner_t rr_ptr;
  idx_t   idx;
  logic   found;

  // Search rr_ptr, rr_ptr+1, ... with wrap-around. idx carries one spare bit so
  // rr_ptr+i never overflows before the modulo-N_REQ correction.
  // NOTE: every variable written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + idx_t'(i);
      if (idx >= idx_t'(N_REQ)) idx = idx - idx_t'(N_REQ);
      if (!found && bus.req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  // The pointer advances only when a response is actually consumed, so a
  // requester that is granted but aborted by reset gets no credit.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      rr_ptr <= '0;
    end else if (state == RESP && bus.rsp_ack[owner]) begin
      rr_ptr <= (owner == owner_t'(N_REQ - 1)) ? '0 : owner + 1'b1;
    end
  end
`endif

  // Operand mux for the current winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == owner_t'(i)) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // ---------------------------------------------------------------------------
  // An operand handshake is done if its strobe already dropped, or if it is
  // being acknowledged this cycle; both done means the edge leaves ISSUE.
  assign a_done = !a_stb || bus.mul_a_ack;
  assign b_done = !b_stb || bus.mul_b_ack;

  always_comb begin
    state_nxt     = state;
    grant         = 1'b0;
    z_take        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.mul_z_ack = 1'b0;

    unique case (state)
      IDLE: begin
        if (any_valid) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          // Gated by reset: the FSM sits in IDLE during reset, yet req_ready
          // must stay low then even when requests are pending.
          bus.req_ready[winner] = iRstn;
        end
      end
      ISSUE: begin
        if (a_done && b_done) state_nxt = WAIT_Z;
      end
      WAIT_Z: begin
        bus.mul_z_ack = bus.mul_z_stb;
        if (bus.mul_z_stb) begin
          z_take    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid[owner] = 1'b1;
        if (bus.rsp_ack[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand, owner and response-data registers are reset even though
  // they are only datapath: they drive outputs directly, and those must read 0
  // during and straight after reset.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      op_a       <= '0;
      op_b       <= '0;
      owner      <= '0;
      a_stb      <= 1'b0;
      b_stb      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (grant) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        owner <= winner;
        a_stb <= 1'b1;
        b_stb <= 1'b1;
      end else begin
        // Each operand strobe retires on its own acknowledge.
        if (a_stb && bus.mul_a_ack) a_stb <= 1'b0;
        if (b_stb && bus.mul_b_ack) b_stb <= 1'b0;
      end
      // rsp_data changes only here, so it holds from rsp_valid rise through
      // idle until the next product capture.
      if (z_take) rsp_data_q <= bus.mul_result;
    end
  end

  assign bus.mul_data_a = op_a;
  assign bus.mul_data_b = op_b;
  assign bus.mul_a_stb  = a_stb;
  assign bus.mul_b_stb  = b_stb;
  assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_arbiter
//
// Directed bench for fp_mul_arbiter (N_REQ = 4). A behavioural multiplier with
// programmable a/b acknowledge and product delays sits on the multiplier side.
// Expected (owner, product) pairs are pushed to a scoreboard queue at grant
// time and popped when a response appears. Inputs change 1 time unit after the
// falling edge; outputs are sampled shortly after that, well away from the
// rising edge.
// -----------------------------------------------------------------------------
module tb_fp_mul_arbiter;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.N_REQ(N)) bus ();

  fp_mul_arbiter #(.N_REQ(N)) dut (
    .iClk  (clk),
    .iRstn (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];

  int vectors    = 0;
  int miscompares = 0;

  // Per-requester operands and their IEEE-754 products (hand-computed).
  logic [31:0] op_a_t [N];
  logic [31:0] op_b_t [N];
  logic [31:0] prod_t [N];

  // Expected strobe/ack pattern for the staggered-ack step, cycles 1..5.
  int exp_a_stb [5] = '{1, 0, 0, 0, 0};
  int exp_b_stb [5] = '{1, 1, 1, 1, 0};
  int exp_z_ack [5] = '{0, 0, 0, 0, 1};

  // ---------------------------------------------------------------------------
  // Multiplier model
  // ---------------------------------------------------------------------------
  int          a_dly = 0;
  int          b_dly = 0;
  int          z_dly = 0;
  int          a_cnt;
  int          b_cnt;
  int          z_cnt;
  logic        hs_a;
  logic        hs_b;
  logic        hs_z;
  logic        got_a;
  logic        got_b;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic [31:0] val_a;
  logic [31:0] val_b;

  function automatic logic [31:0] fp_mul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000; //  2.0 *  3.0
      {32'h3FC00000, 32'h40000000}: return 32'h40400000; //  1.5 *  2.0
      {32'h40800000, 32'h3F000000}: return 32'h40000000; //  4.0 *  0.5
      {32'hC0000000, 32'h40400000}: return 32'hC0C00000; // -2.0 *  3.0
      default:                      return a ^ b;
    endcase
  endfunction

  initial begin
    bus.mul_a_ack  = 1'b0;
    bus.mul_b_ack  = 1'b0;
    bus.mul_z_stb  = 1'b0;
    bus.mul_result = '0;
    a_cnt = 0; b_cnt = 0; z_cnt = 0;
    got_a = 1'b0; got_b = 1'b0;
    val_a = '0; val_b = '0;
    forever begin
      @(posedge clk);
      hs_a  = bus.mul_a_stb && bus.mul_a_ack;
      hs_b  = bus.mul_b_stb && bus.mul_b_ack;
      hs_z  = bus.mul_z_stb && bus.mul_z_ack;
      cap_a = bus.mul_data_a;
      cap_b = bus.mul_data_b;
      #1;
      if (!rst_n) begin
        bus.mul_a_ack = 1'b0;
        bus.mul_b_ack = 1'b0;
        bus.mul_z_stb = 1'b0;
        a_cnt = 0; b_cnt = 0; z_cnt = 0;
        got_a = 1'b0; got_b = 1'b0;
      end else begin
        if (hs_a) begin got_a = 1'b1; val_a = cap_a; end
        if (hs_b) begin got_b = 1'b1; val_b = cap_b; end
        if (hs_z) begin got_a = 1'b0; got_b = 1'b0; z_cnt = 0; end
        if (bus.mul_a_stb) begin
          bus.mul_a_ack = (a_cnt >= a_dly);
          a_cnt++;
        end else begin
          bus.mul_a_ack = 1'b0;
          a_cnt = 0;
        end
        if (bus.mul_b_stb) begin
          bus.mul_b_ack = (b_cnt >= b_dly);
          b_cnt++;
        end else begin
          bus.mul_b_ack = 1'b0;
          b_cnt = 0;
        end
        if (got_a && got_b) begin
          bus.mul_z_stb  = (z_cnt >= z_dly);
          bus.mul_result = fp_mul_model(val_a, val_b);
          z_cnt++;
        end else begin
          bus.mul_z_stb = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant, check who got it, queue the expected response
  // and move past the grant edge.
  task automatic wait_grant(input string tag, input int exp_idx, input logic [31:0] exp_data);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (|bus.req_ready) break;
      step();
    end
    check({tag, " grant"}, 32'(bus.req_ready), 32'(1 << exp_idx));
    sb.push_back('{idx: exp_idx, data: exp_data});
    step();
  endtask

  // Wait (bounded) for a response, compare it with the scoreboard head and
  // acknowledge it for one cycle.
  task automatic serve(input string tag);
    sb_t e;
    for (int i = 0; i < 40; i++) begin
      if (|bus.rsp_valid) break;
      step();
    end
    check({tag, " sb not empty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else                e = '{idx: 0, data: 32'h0};
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << e.idx));
    check({tag, " rsp_data"},  bus.rsp_data,       e.data);
    bus.rsp_ack = N'(1 << e.idx);
    step();
    bus.rsp_ack = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready),  32'd0);
    check({tag, " rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    check({tag, " mul_a_stb"},  32'(bus.mul_a_stb),  32'd0);
    check({tag, " mul_b_stb"},  32'(bus.mul_b_stb),  32'd0);
    check({tag, " mul_z_ack"},  32'(bus.mul_z_ack),  32'd0);
    check({tag, " rsp_data"},   bus.rsp_data,        32'd0);
    check({tag, " mul_data_a"}, bus.mul_data_a,      32'd0);
    check({tag, " mul_data_b"}, bus.mul_data_b,      32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    op_a_t[0] = 32'h40000000; op_b_t[0] = 32'h40400000; prod_t[0] = 32'h40C00000;
    op_a_t[1] = 32'h3FC00000; op_b_t[1] = 32'h40000000; prod_t[1] = 32'h40400000;
    op_a_t[2] = 32'h40800000; op_b_t[2] = 32'h3F000000; prod_t[2] = 32'h40000000;
    op_a_t[3] = 32'hC0000000; op_b_t[3] = 32'h40400000; prod_t[3] = 32'hC0C00000;

    bus.req_valid = '0;
    bus.rsp_ack   = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[32*i +: 32] = op_a_t[i];
      bus.req_b[32*i +: 32] = op_b_t[i];
    end

    // Reset state.
    step();
    check_outputs_zero("reset");
    step();
    rst_n = 1'b1;

    // 1: single request, immediate acks, cycle-exact latency.
    step();
    bus.req_valid = 4'b0001;
    #1;
    check("t1 req_ready c0", 32'(bus.req_ready), 32'h1);
    sb.push_back('{idx: 0, data: prod_t[0]});
    step();
    bus.req_valid = '0;
    check("t1 mul_a_stb c1",  32'(bus.mul_a_stb), 32'd1);
    check("t1 mul_b_stb c1",  32'(bus.mul_b_stb), 32'd1);
    check("t1 mul_data_a c1", bus.mul_data_a,     op_a_t[0]);
    check("t1 mul_data_b c1", bus.mul_data_b,     op_b_t[0]);
    step();
    check("t1 mul_z_ack c2",  32'(bus.mul_z_ack), 32'd1);
    check("t1 rsp_valid c2",  32'(bus.rsp_valid), 32'd0);
    step();
    check("t1 rsp_valid c3",  32'(bus.rsp_valid), 32'h1);
    serve("t1");
    #1;
    check("t1 idle req_ready", 32'(bus.req_ready), 32'd0);
    check("t1 idle rsp_data",  bus.rsp_data,       prod_t[0]);

    // 2: full contention from a fresh rr_ptr.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
      wait_grant("t2", 0, prod_t[0]);
`else
      wait_grant("t2", k % N, prod_t[k % N]);
`endif
      if (k == 4) bus.req_valid = '0;
      serve("t2");
    end

    // 3: mul_b_ack three cycles after mul_a_ack.
    b_dly = 3;
    bus.req_valid = 4'b0100;
    wait_grant("t3", 2, prod_t[2]);
    bus.req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3 mul_a_stb c%0d", c + 1), 32'(bus.mul_a_stb), 32'(exp_a_stb[c]));
      check($sformatf("t3 mul_b_stb c%0d", c + 1), 32'(bus.mul_b_stb), 32'(exp_b_stb[c]));
      check($sformatf("t3 mul_z_ack c%0d", c + 1), 32'(bus.mul_z_ack), 32'(exp_z_ack[c]));
      step();
    end
    check("t3 rsp_valid c6", 32'(bus.rsp_valid), 32'b0100);
    serve("t3");
    b_dly = 0;

    // 4: owner 2 holds its response; requester 1 pulses a stray ack.
    bus.req_valid = 4'b0100;
    wait_grant("t4", 2, prod_t[2]);
    bus.req_valid = '0;
    for (int i = 0; i < 40; i++) begin
      if (|bus.rsp_valid) break;
      step();
    end
    bus.req_valid = 4'b0011;
    #1;
    for (int h = 0; h < 5; h++) begin
      check($sformatf("t4 hold rsp_valid h%0d", h), 32'(bus.rsp_valid), 32'b0100);
      check($sformatf("t4 hold rsp_data h%0d", h),  bus.rsp_data,       prod_t[2]);
      check($sformatf("t4 hold req_ready h%0d", h), 32'(bus.req_ready), 32'd0);
      bus.rsp_ack = (h == 1) ? 4'b0010 : 4'b0000;
      step();
    end
    bus.rsp_ack = '0;
    serve("t4 held");
    // rr_ptr is now 3: requester 0 wins by wrap-around, then requester 1.
    wait_grant("t4 wrap", 0, prod_t[0]);
    bus.req_valid = 4'b0010;
    serve("t4 wrap");
    wait_grant("t4 next", 1, prod_t[1]);
    bus.req_valid = '0;
    serve("t4 next");

    // 5: reset during WAIT_Z. rr_ptr is 2 beforehand, so 1010 after reset
    // picks requester 1 only if rr_ptr was cleared.
    z_dly = 4;
    bus.req_valid = 4'b0010;
    wait_grant("t5", 1, prod_t[1]);
    bus.req_valid = '0;
    step();
    check("t5 in WAIT_Z mul_z_ack", 32'(bus.mul_z_ack), 32'd0);
    step();
    bus.req_valid = 4'b1010;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5 async reset");
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    z_dly = 0;
    wait_grant("t5 rr_ptr cleared", 1, prod_t[1]);
    bus.req_valid = 4'b1000;
    serve("t5 rr_ptr cleared");
    wait_grant("t5 req3", 3, prod_t[3]);
    bus.req_valid = '0;
    serve("t5 req3");

    // 6: requester 1 raises then withdraws while requester 0 owns the unit.
    z_dly = 3;
    bus.req_valid = 4'b0001;
    wait_grant("t6", 0, prod_t[0]);
    bus.req_valid = 4'b0010;
    #1;
    check("t6 busy req_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.req_valid = '0;
    serve("t6");
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t6 idle req_ready i%0d", i), 32'(bus.req_ready), 32'd0);
      check($sformatf("t6 idle mul_a_stb i%0d", i), 32'(bus.mul_a_stb), 32'd0);
      check($sformatf("t6 idle rsp_valid i%0d", i), 32'(bus.rsp_valid), 32'd0);
      step();
    end
    z_dly = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
